// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with valid/ready handshake,
// optional one-entry skid buffer, and stage-wide stall (hold) and
// bubble (flush) controls. The payload is split into a control field,
// which reads as zero whenever its entry is invalid, and a data field.
//
// Occupancy is kept as a small state machine whose encoding doubles as
// the per-entry valid bits: bit 0 is the main entry, bit 1 the skid entry.
// With SKID=0 the FULL state is never entered and the skid registers
// stay at their reset value, so they reduce to constants.

module pipe_skid_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              stall,
  input  logic              bubble,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  // Occupancy states; the encoding is {skid valid, main valid}.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_FULL  = 2'b11
  } occ_e;

  localparam bit HAS_SKID = (SKID != 32'sd0);

  occ_e              occ_q;
  occ_e              occ_d;
  logic [CTRL_W-1:0] m_ctrl_q;
  logic [CTRL_W-1:0] m_ctrl_d;
  logic [DATA_W-1:0] m_data_q;
  logic [DATA_W-1:0] m_data_d;
  logic [CTRL_W-1:0] s_ctrl_q;
  logic [CTRL_W-1:0] s_ctrl_d;
  logic [DATA_W-1:0] s_data_q;
  logic [DATA_W-1:0] s_data_d;

  logic              m_v_s;
  logic              s_v_s;
  logic              in_xfer_s;
  logic              out_xfer_s;

  // Decode the occupancy state into per-entry valid bits and the entry count.
  always_comb begin
    m_v_s   = 1'b0;
    s_v_s   = 1'b0;
    o_count = 2'd0;
    case (occ_q)
      OCC_EMPTY: begin
        m_v_s   = 1'b0;
        s_v_s   = 1'b0;
        o_count = 2'd0;
      end
      OCC_ONE: begin
        m_v_s   = 1'b1;
        s_v_s   = 1'b0;
        o_count = 2'd1;
      end
      OCC_FULL: begin
        m_v_s   = 1'b1;
        s_v_s   = 1'b1;
        o_count = 2'd2;
      end
      default: begin
        m_v_s   = 1'b0;
        s_v_s   = 1'b0;
        o_count = 2'd0;
      end
    endcase
  end

  // Handshake outputs and transfer qualifiers; with a skid entry, ready
  // depends only on registered state so i_ready never reaches o_ready.
  always_comb begin
    o_valid = m_v_s & ~stall;
    if (HAS_SKID) begin
      o_ready = ~s_v_s & ~stall & nrst;
    end else begin
      o_ready = (~m_v_s | i_ready) & ~stall & nrst;
    end
    in_xfer_s  = i_valid & o_ready;
    out_xfer_s = o_valid & i_ready;
    o_ctrl     = m_ctrl_q;
    o_data     = m_data_q;
  end

  // Next-state and payload update: stall holds everything, bubble wipes
  // everything (including the offered input), otherwise move entries in
  // FIFO order. A cleared valid bit always clears its control field.
  always_comb begin
    occ_d    = occ_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    if (stall) begin
      occ_d = occ_q;
    end else if (bubble) begin
      occ_d    = OCC_EMPTY;
      m_ctrl_d = {CTRL_W{1'b0}};
      m_data_d = {DATA_W{1'b0}};
      s_ctrl_d = {CTRL_W{1'b0}};
      s_data_d = {DATA_W{1'b0}};
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (in_xfer_s) begin
            m_ctrl_d = i_ctrl;
            m_data_d = i_data;
            occ_d    = OCC_ONE;
          end else begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            // Head leaves while the new beat takes its place.
            m_ctrl_d = i_ctrl;
            m_data_d = i_data;
            occ_d    = OCC_ONE;
          end else if (in_xfer_s) begin
            // Only reachable with a skid entry: downstream stalled, park it.
            if (HAS_SKID) begin
              s_ctrl_d = i_ctrl;
              s_data_d = i_data;
              occ_d    = OCC_FULL;
            end else begin
              occ_d = OCC_ONE;
            end
          end else if (out_xfer_s) begin
            m_ctrl_d = {CTRL_W{1'b0}};
            occ_d    = OCC_EMPTY;
          end else begin
            occ_d = OCC_ONE;
          end
        end
        OCC_FULL: begin
          if (out_xfer_s) begin
            // Skid entry moves up; input cannot arrive since ready is low.
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
            s_ctrl_d = {CTRL_W{1'b0}};
            occ_d    = OCC_ONE;
          end else begin
            occ_d = OCC_FULL;
          end
        end
        default: begin
          // Unused encoding: recover to a clean empty stage.
          occ_d    = OCC_EMPTY;
          m_ctrl_d = {CTRL_W{1'b0}};
          m_data_d = {DATA_W{1'b0}};
          s_ctrl_d = {CTRL_W{1'b0}};
          s_data_d = {DATA_W{1'b0}};
        end
      endcase
    end
  end

  // State and payload registers with asynchronous clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      occ_q    <= OCC_EMPTY;
      m_ctrl_q <= {CTRL_W{1'b0}};
      m_data_q <= {DATA_W{1'b0}};
      s_ctrl_q <= {CTRL_W{1'b0}};
      s_data_q <= {DATA_W{1'b0}};
    end else begin
      occ_q    <= occ_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: drives a SKID=1 and a SKID=0 instance with directed
// vectors, checks both every cycle against a queue-based occupancy model,
// and pins the model with hand-computed literal expectations.

module tb_pipe_skid_reg;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  // SKID=1 instance signals
  logic st1 = 1'b0, bb1 = 1'b0, iv1 = 1'b0, ir1 = 1'b0;
  logic [7:0] ic1 = 8'h00;
  logic [63:0] id1 = 64'h0;
  logic or1, ov1;
  logic [7:0] oc1;
  logic [63:0] od1;
  logic [1:0] cnt1;

  // SKID=0 instance signals
  logic st0 = 1'b0, bb0 = 1'b0, iv0 = 1'b0, ir0 = 1'b0;
  logic [7:0] ic0 = 8'h00;
  logic [63:0] id0 = 64'h0;
  logic or0, ov0;
  logic [7:0] oc0;
  logic [63:0] od0;
  logic [1:0] cnt0;

  pipe_skid_reg #(.CTRL_W(8), .DATA_W(64), .SKID(1)) dut1 (
    .clk(clk), .nrst(nrst), .stall(st1), .bubble(bb1),
    .i_valid(iv1), .o_ready(or1), .i_ctrl(ic1), .i_data(id1),
    .o_valid(ov1), .i_ready(ir1), .o_ctrl(oc1), .o_data(od1),
    .o_count(cnt1)
  );

  pipe_skid_reg #(.CTRL_W(8), .DATA_W(64), .SKID(0)) dut0 (
    .clk(clk), .nrst(nrst), .stall(st0), .bubble(bb0),
    .i_valid(iv0), .o_ready(or0), .i_ctrl(ic0), .i_data(id0),
    .o_valid(ov0), .i_ready(ir0), .o_ctrl(oc0), .o_data(od0),
    .o_count(cnt0)
  );

  typedef struct packed {
    logic [7:0]  c;
    logic [63:0] d;
  } ent_t;

  ent_t q1[$];
  ent_t q0[$];
  bit   dz1 = 1'b1;   // data output must read zero (after reset/bubble)
  bit   dz0 = 1'b1;
  bit   acc1, acc0;
  bit   mon_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each instance is a FIFO of capacity 2 (SKID=1) or
  // 1 with same-cycle replacement (SKID=0).
  initial forever begin
    @(posedge clk or negedge nrst);
    if (!nrst) begin
      q1.delete(); q0.delete();
      dz1 = 1'b1; dz0 = 1'b1;
    end else begin
      if (!st1) begin
        if (bb1) begin
          q1.delete(); dz1 = 1'b1;
        end else begin
          acc1 = iv1 && (q1.size() < 2);
          if (q1.size() > 0 && ir1) void'(q1.pop_front());
          if (acc1) begin q1.push_back('{ic1, id1}); dz1 = 1'b0; end
        end
      end
      if (!st0) begin
        if (bb0) begin
          q0.delete(); dz0 = 1'b1;
        end else begin
          acc0 = iv0 && (q0.size() == 0 || ir0);
          if (q0.size() > 0 && ir0) void'(q0.pop_front());
          if (acc0) begin q0.push_back('{ic0, id0}); dz0 = 1'b0; end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("m1.o_valid", 64'(ov1), 64'(q1.size() > 0 && !st1));
      chk("m1.o_ready", 64'(or1), 64'(nrst && !st1 && q1.size() < 2));
      chk("m1.o_count", 64'(cnt1), 64'(q1.size()));
      chk("m1.o_ctrl", 64'(oc1), (q1.size() > 0) ? 64'(q1[0].c) : 64'h0);
      if (q1.size() > 0) chk("m1.o_data", od1, q1[0].d);
      else if (dz1) chk("m1.o_data_zero", od1, 64'h0);
      chk("m0.o_valid", 64'(ov0), 64'(q0.size() > 0 && !st0));
      chk("m0.o_ready", 64'(or0), 64'(nrst && !st0 && (q0.size() == 0 || ir0)));
      chk("m0.o_count", 64'(cnt0), 64'(q0.size()));
      chk("m0.o_ctrl", 64'(oc0), (q0.size() > 0) ? 64'(q0[0].c) : 64'h0);
      if (q0.size() > 0) chk("m0.o_data", od0, q0[0].d);
      else if (dz0) chk("m0.o_data_zero", od0, 64'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with input offered
    #2 nrst = 1'b0;
    mon_en = 1'b1;
    iv1 = 1'b1; ic1 = 8'h5A; id1 = 64'h1;
    tick();
    chk("rst.o_valid", 64'(ov1), 64'h0);
    chk("rst.o_ctrl", 64'(oc1), 64'h0);
    chk("rst.o_data", od1, 64'h0);
    chk("rst.o_count", 64'(cnt1), 64'h0);
    chk("rst.o_ready", 64'(or1), 64'h0);
    chk("rst0.o_ready", 64'(or0), 64'h0);
    tick();
    nrst = 1'b1;
    #1;
    chk("rel.o_ready", 64'(or1), 64'h1);
    tick();
    chk("first.o_valid", 64'(ov1), 64'h1);
    chk("first.o_ctrl", 64'(oc1), 64'h5A);
    chk("first.o_data", od1, 64'h1);
    chk("first.o_count", 64'(cnt1), 64'h1);

    // Drain last entry with no new input
    iv1 = 1'b0; ir1 = 1'b1;
    tick();
    chk("drain.o_valid", 64'(ov1), 64'h0);
    chk("drain.o_ctrl", 64'(oc1), 64'h0);
    chk("drain.o_count", 64'(cnt1), 64'h0);

    // Full-rate stream 0..9, latency 1
    for (int i = 0; i < 10; i++) begin
      iv1 = 1'b1; ic1 = 8'(i); id1 = 64'(i) * 64'h1111;
      tick();
      chk("stream.o_valid", 64'(ov1), 64'h1);
      chk("stream.o_ctrl", 64'(oc1), 64'(i));
      chk("stream.o_data", od1, 64'(i) * 64'h1111);
    end
    iv1 = 1'b0;
    tick();
    chk("stream_end.o_valid", 64'(ov1), 64'h0);

    // Backpressure: one extra beat absorbed into the skid entry
    ir1 = 1'b1; iv1 = 1'b1; ic1 = 8'h20; id1 = 64'h20;
    tick();
    ic1 = 8'h21; id1 = 64'h21;
    tick();
    ir1 = 1'b0; ic1 = 8'h22; id1 = 64'h22;
    tick();
    chk("bp.o_count", 64'(cnt1), 64'h2);
    chk("bp.o_ready", 64'(or1), 64'h0);
    chk("bp.o_ctrl", 64'(oc1), 64'h21);
    ic1 = 8'h23; id1 = 64'h23;
    tick();
    chk("bp_hold.o_count", 64'(cnt1), 64'h2);
    chk("bp_hold.o_ctrl", 64'(oc1), 64'h21);
    ir1 = 1'b1;
    #1;
    chk("bp_noflow.o_ready", 64'(or1), 64'h0);
    tick();
    chk("bp_rel.o_ctrl", 64'(oc1), 64'h22);
    chk("bp_rel.o_count", 64'(cnt1), 64'h1);
    chk("bp_rel.o_ready", 64'(or1), 64'h1);
    tick();
    chk("bp_next.o_ctrl", 64'(oc1), 64'h23);
    iv1 = 1'b0;
    tick();
    chk("bp_end.o_valid", 64'(ov1), 64'h0);

    // Stall and bubble together while FULL, then bubble alone
    ir1 = 1'b0; iv1 = 1'b1; ic1 = 8'h30; id1 = 64'h30;
    tick();
    ic1 = 8'h31; id1 = 64'h31;
    tick();
    st1 = 1'b1; bb1 = 1'b1; ic1 = 8'h32; id1 = 64'h32;
    #1;
    chk("sb.o_valid", 64'(ov1), 64'h0);
    chk("sb.o_ready", 64'(or1), 64'h0);
    chk("sb.o_count", 64'(cnt1), 64'h2);
    tick();
    chk("sb_hold.o_count", 64'(cnt1), 64'h2);
    chk("sb_hold.o_ctrl", 64'(oc1), 64'h30);
    st1 = 1'b0;
    tick();
    chk("bub.o_count", 64'(cnt1), 64'h0);
    chk("bub.o_ctrl", 64'(oc1), 64'h0);
    chk("bub.o_data", od1, 64'h0);
    chk("bub.o_valid", 64'(ov1), 64'h0);
    // Bubble with ready high still drops the offered input
    tick();
    chk("bub_drop.o_count", 64'(cnt1), 64'h0);
    bb1 = 1'b0; iv1 = 1'b0;
    tick();

    // Stall mid-burst
    ir1 = 1'b1; iv1 = 1'b1; ic1 = 8'h40; id1 = 64'h40;
    tick();
    st1 = 1'b1; ic1 = 8'h41; id1 = 64'h41;
    #1;
    chk("stall.o_valid", 64'(ov1), 64'h0);
    chk("stall.o_ready", 64'(or1), 64'h0);
    tick();
    tick();
    chk("stall_hold.o_count", 64'(cnt1), 64'h1);
    chk("stall_hold.o_ctrl", 64'(oc1), 64'h40);
    st1 = 1'b0;
    tick();
    chk("stall_rel.o_ctrl", 64'(oc1), 64'h41);
    iv1 = 1'b0;
    tick();

    // SKID=0: combinational ready pass-through
    ir0 = 1'b0; iv0 = 1'b1; ic0 = 8'h50; id0 = 64'h50;
    tick();
    chk("s0.o_count", 64'(cnt0), 64'h1);
    chk("s0.o_ctrl", 64'(oc0), 64'h50);
    ic0 = 8'h51; id0 = 64'h51;
    #1;
    chk("s0_bp.o_ready", 64'(or0), 64'h0);
    tick();
    chk("s0_bp.o_ctrl", 64'(oc0), 64'h50);
    ir0 = 1'b1;
    #1;
    chk("s0_pass.o_ready", 64'(or0), 64'h1);
    tick();
    chk("s0_pass.o_ctrl", 64'(oc0), 64'h51);
    chk("s0_pass.o_count", 64'(cnt0), 64'h1);
    iv0 = 1'b0;
    tick();
    chk("s0_drain.o_valid", 64'(ov0), 64'h0);
    chk("s0_drain.o_ctrl", 64'(oc0), 64'h0);
    chk("s0_drain.o_count", 64'(cnt0), 64'h0);

    // Asynchronous reset mid-operation
    ir1 = 1'b0; iv1 = 1'b1; ic1 = 8'h60; id1 = 64'h60;
    tick();
    #3 nrst = 1'b0;
    #1;
    chk("arst.o_valid", 64'(ov1), 64'h0);
    chk("arst.o_count", 64'(cnt1), 64'h0);
    chk("arst.o_ctrl", 64'(oc1), 64'h0);
    chk("arst.o_ready", 64'(or1), 64'h0);
    iv1 = 1'b0;
    tick();
    nrst = 1'b1;

    // Mixed traffic on both instances, checked by the model
    for (int n = 0; n < 400; n++) begin
      st1 = ($urandom_range(0, 9) == 0);
      bb1 = ($urandom_range(0, 24) == 0);
      iv1 = 1'($urandom);
      ir1 = ($urandom_range(0, 3) != 0);
      ic1 = 8'($urandom);
      id1 = {$urandom, $urandom};
      st0 = ($urandom_range(0, 9) == 0);
      bb0 = ($urandom_range(0, 24) == 0);
      iv0 = 1'($urandom);
      ir0 = ($urandom_range(0, 3) != 0);
      ic0 = 8'($urandom);
      id0 = {$urandom, $urandom};
      tick();
    end
    st1 = 1'b0; bb1 = 1'b0; iv1 = 1'b0; ir1 = 1'b1;
    st0 = 1'b0; bb0 = 1'b0; iv0 = 1'b0; ir0 = 1'b1;
    tick();
    tick();
    tick();
    chk("final.o_count1", 64'(cnt1), 64'h0);
    chk("final.o_count0", 64'(cnt0), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with a valid/ready handshake, an optional one-entry skid buffer, and the stage-wide stall (hold) and bubble (flush) controls used by the processor pipeline registers. Payload is split into a control field, which must never leak a stale value, and a data field. One instance sits between each pair of pipeline stages and decouples upstream ready from downstream ready when SKID=1.

## Interface
- CTRL_W, default 8: control-field width; all bits are zero whenever the entry is invalid.
- DATA_W, default 64: data-field width.
- SKID, default 1: 1 gives a two-entry registered-ready stage; 0 gives a single entry with combinational ready pass-through.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- nrst  in  1  asynchronous, active-low reset.
- stall  in  1  freeze. All state holds and no transfers occur. Has priority over bubble.
- bubble  in  1  flush. When stall=0, discards all held entries and any input offered this cycle.
- i_valid  in  1  upstream offers a payload.
- o_ready  out  1  stage accepts the payload.
- i_ctrl  in  CTRL_W  upstream control field.
- i_data  in  DATA_W  upstream data field.
- o_valid  out  1  stage presents a payload.
- i_ready  in  1  downstream accepts the payload.
- o_ctrl  out  CTRL_W  presented control field.
- o_data  out  DATA_W  presented data field.
- o_count  out  2  number of held entries (0..2; 0..1 when SKID=0).

## Operation
- Storage:
  - M (main) drives o_ctrl and o_data; its valid bit is M_v.
  - S (skid) exists only when SKID=1; its valid bit is S_v.
- Transfers:
  - in_xfer = i_valid & o_ready.
  - out_xfer = o_valid & i_ready.
- o_valid = M_v & ~stall.
- o_ready:
  - SKID=1: ~S_v & ~stall & nrst.
  - SKID=0: (~M_v | i_ready) & ~stall & nrst.
- o_count = M_v + S_v, taken from the registered valid bits; it is not gated by stall.
- Priority at each edge: nrst low > stall > bubble > normal transfer.
- stall=1: every register holds its value, including payload and valid bits.
- bubble=1 with stall=0: M_v, S_v, and the M and S ctrl/data fields are all set to 0. The input is dropped even if i_valid=1.
- Normal operation, SKID=1, states EMPTY (M_v=0), ONE (M_v=1, S_v=0), FULL (both valid):
  - EMPTY, in_xfer: M <= input; next state ONE.
  - ONE, in_xfer & out_xfer: M <= input; stays ONE.
  - ONE, in_xfer only: S <= input; next state FULL.
  - ONE, out_xfer only: M_v <= 0 and M ctrl <= 0; next state EMPTY.
  - FULL, out_xfer: M <= S, S_v <= 0, S ctrl <= 0; next state ONE. No in_xfer is possible because o_ready=0.
- Normal operation, SKID=0:
  - in_xfer: M <= input.
  - out_xfer without in_xfer: M_v <= 0 and M ctrl <= 0.
- Whenever a valid bit is cleared, the matching ctrl field is cleared too. Data fields may hold stale values except after reset or bubble, when they are zero.
- Ordering is FIFO. No payload is ever duplicated or lost, except by bubble.

## Timing
- Reset (nrst low, asynchronous): M_v=S_v=0, all ctrl/data=0.
  - Outputs: o_valid=0, o_ctrl=0, o_data=0, o_count=0, o_ready=0.
  - After release: o_ready=1 in the first cycle with stall=0.
- Latency: an input accepted at edge N is presented from edge N when the stage is EMPTY or is being drained. Minimum latency is 1 cycle.
- SKID=1 throughput: 1 transfer per cycle with i_ready held high. o_ready depends only on registers and stall, so there is no combinational path from i_ready to o_ready.
- Backpressure (SKID=1): i_ready falling while streaming → one extra beat is absorbed into S, then o_ready=0 from the next cycle.
- FULL + out_xfer: o_ready returns to 1 in the following cycle.
- stall asserted mid-burst: transfers stop in the same cycle. On release, resume from identical state.
- Reset asserted mid-operation: all entries are discarded immediately. No partial transfer completes at that edge.

## Test plan
- Reset with nrst low and i_valid=1 → o_valid=0, o_ctrl=0, o_data=0, o_count=0, o_ready=0. First edge after release with i_ctrl=8'h5A, i_data=64'h1 → o_valid=1, o_ctrl=8'h5A.
- SKID=1 stream of 0..9 with i_ready=1 → outputs 0..9 in order, one per cycle, with latency 1.
- SKID=1: drop i_ready while streaming → exactly one extra beat is accepted, o_count=2, o_ready=0. Raise i_ready → order preserved and o_ready=1 one cycle later.
- stall=1 and bubble=1 together while FULL → contents held, o_valid=0, o_ready=0. Release stall with bubble=1 → o_count=0, o_ctrl=0, o_data=0, and the offered input is dropped.
- SKID=0 with i_ready=0 and M_v=1 → o_ready=0. Set i_ready=1 → o_ready=1 in the same cycle, in and out occur on the same edge, and o_count stays 1.
- Last entry drained with no new input → o_valid=0 and o_ctrl=0 after the edge.
